// File: rtl/dcache_ctrl.sv
// Data-cache miss controller: accepts one LSQ load/store at a time, looks it
// up in the cache, services misses with a memory LOAD, fills the line,
// writes back a dirty victim if the cache reports one, then replays the
// original access so completion always comes from a cache hit.
module dcache_ctrl #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 29 - IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  // LSQ side
  input  logic             lsq_valid,
  input  logic             lsq_is_store,
  input  logic [31:0]      lsq_addr,
  input  logic [63:0]      lsq_data,
  input  logic [2:0]       lsq_size,
  output logic             lsq_ready,
  output logic             lsq_done,
  output logic [63:0]      lsq_rd_data,
  // Cache side
  output logic             dc_rd_en,
  output logic             dc_wr_en_lsq,
  output logic             dc_wr_en_mem,
  output logic [IDX_W-1:0] dc_idx,
  output logic [TAG_W-1:0] dc_tag,
  output logic [63:0]      dc_wr_data,
  output logic [2:0]       dc_size,
  output logic             dc_offset,
  output logic             dc_changed_data,
  input  logic             dc_rd_valid,
  input  logic             dc_wr_valid,
  input  logic [63:0]      dc_rd_data,
  input  logic             dc_evict_en,
  input  logic [63:0]      dc_evict_data,
  input  logic [31:0]      dc_evict_addr,
  // Memory side
  output logic [1:0]       mem_command,
  output logic [31:0]      mem_addr,
  output logic [63:0]      mem_data,
  input  logic [3:0]       mem_response,
  input  logic [3:0]       mem_tag,
  input  logic [63:0]      mem_rd_data
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, EVICT_CHK, WB
  } state_e;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [31:2] addr_q, addr_d;          // byte-lane bits are never needed
  logic [63:0] data_q, data_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  miss_tag_q, miss_tag_d;
  logic [63:0] fill_q, fill_d;
  logic [31:3] ev_addr_q, ev_addr_d;    // victims are always 8-byte aligned
  logic [63:0] ev_data_q, ev_data_d;
  logic        done_q, done_d;
  logic [63:0] rd_data_q, rd_data_d;

  // Low address bits are intentionally discarded (block-aligned traffic).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lsq_addr[1:0], dc_evict_addr[2:0]};

  // State and transaction latches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      size_q     <= '0;
      miss_tag_q <= '0;
      fill_q     <= '0;
      ev_addr_q  <= '0;
      ev_data_q  <= '0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      size_q     <= size_d;
      miss_tag_q <= miss_tag_d;
      fill_q     <= fill_d;
      ev_addr_q  <= ev_addr_d;
      ev_data_q  <= ev_data_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Next-state, latch updates and per-state strobes/commands.
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    addr_d       = addr_q;
    data_d       = data_q;
    size_d       = size_q;
    miss_tag_d   = miss_tag_q;
    fill_d       = fill_q;
    ev_addr_d    = ev_addr_q;
    ev_data_d    = ev_data_q;
    done_d       = 1'b0;
    rd_data_d    = rd_data_q;
    lsq_ready    = 1'b0;
    dc_rd_en     = 1'b0;
    dc_wr_en_lsq = 1'b0;
    dc_wr_en_mem = 1'b0;
    dc_wr_data   = '0;
    mem_command  = CMD_NONE;
    mem_addr     = '0;
    mem_data     = '0;

    unique case (state_q)
      IDLE: begin
        lsq_ready = 1'b1;
        if (lsq_valid) begin
          is_store_d = lsq_is_store;
          addr_d     = lsq_addr[31:2];
          data_d     = lsq_data;
          size_d     = lsq_size;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (is_store_q) begin
          dc_wr_en_lsq = 1'b1;
          dc_wr_data   = data_q;
          if (dc_wr_valid) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = MISS_REQ;
          end
        end else begin
          dc_rd_en = 1'b1;
          if (dc_rd_valid) begin
            rd_data_d = dc_rd_data;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        mem_command = CMD_LOAD;
        mem_addr    = {addr_q[31:3], 3'b000};
        if (mem_response != 4'd0) begin
          miss_tag_d = mem_response;
          state_d    = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if ((mem_tag != 4'd0) && (mem_tag == miss_tag_q)) begin
          fill_d  = mem_rd_data;
          state_d = FILL;
        end
      end
      FILL: begin
        dc_wr_en_mem = 1'b1;
        dc_wr_data   = fill_q;
        state_d      = EVICT_CHK;
      end
      EVICT_CHK: begin
        if (dc_evict_en) begin
          ev_addr_d = dc_evict_addr[31:3];
          ev_data_d = dc_evict_data;
          state_d   = WB;
        end else begin
          state_d = LOOKUP;
        end
      end
      WB: begin
        mem_command = CMD_STORE;
        mem_addr    = {ev_addr_q, 3'b000};
        mem_data    = ev_data_q;
        if (mem_response != 4'd0) begin
          state_d = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Cache addressing always follows the latched request.
  always_comb begin
    dc_tag          = addr_q[31:3+IDX_W];
    dc_idx          = addr_q[2+IDX_W:3];
    dc_offset       = addr_q[2];
    dc_size         = size_q;
    dc_changed_data = 1'b0;
    lsq_done        = done_q;
    lsq_rd_data     = rd_data_q;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: table of hit vectors plus hand-written miss,
// eviction, reset-abandon and held-valid sequences; completions are checked
// against a queue of expected load data.
module tb_dcache_ctrl;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned TAG_W = 25;

  logic             clock = 1'b0;
  logic             reset;
  logic             lsq_valid, lsq_is_store;
  logic [31:0]      lsq_addr;
  logic [63:0]      lsq_data;
  logic [2:0]       lsq_size;
  logic             lsq_ready, lsq_done;
  logic [63:0]      lsq_rd_data;
  logic             dc_rd_en, dc_wr_en_lsq, dc_wr_en_mem;
  logic [IDX_W-1:0] dc_idx;
  logic [TAG_W-1:0] dc_tag;
  logic [63:0]      dc_wr_data;
  logic [2:0]       dc_size;
  logic             dc_offset, dc_changed_data;
  logic             dc_rd_valid, dc_wr_valid;
  logic [63:0]      dc_rd_data;
  logic             dc_evict_en;
  logic [63:0]      dc_evict_data;
  logic [31:0]      dc_evict_addr;
  logic [1:0]       mem_command;
  logic [31:0]      mem_addr;
  logic [63:0]      mem_data;
  logic [3:0]       mem_response, mem_tag;
  logic [63:0]      mem_rd_data;

  dcache_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .lsq_valid(lsq_valid), .lsq_is_store(lsq_is_store), .lsq_addr(lsq_addr),
    .lsq_data(lsq_data), .lsq_size(lsq_size), .lsq_ready(lsq_ready),
    .lsq_done(lsq_done), .lsq_rd_data(lsq_rd_data),
    .dc_rd_en(dc_rd_en), .dc_wr_en_lsq(dc_wr_en_lsq), .dc_wr_en_mem(dc_wr_en_mem),
    .dc_idx(dc_idx), .dc_tag(dc_tag), .dc_wr_data(dc_wr_data), .dc_size(dc_size),
    .dc_offset(dc_offset), .dc_changed_data(dc_changed_data),
    .dc_rd_valid(dc_rd_valid), .dc_wr_valid(dc_wr_valid), .dc_rd_data(dc_rd_data),
    .dc_evict_en(dc_evict_en), .dc_evict_data(dc_evict_data),
    .dc_evict_addr(dc_evict_addr),
    .mem_command(mem_command), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_response(mem_response), .mem_tag(mem_tag), .mem_rd_data(mem_rd_data)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int fill_cnt = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_load;

  typedef struct {
    logic             st;
    logic [31:0]      addr;
    logic [63:0]      data;
    logic [2:0]       size;
    logic [63:0]      rdata;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_off;
  } vec_t;
  vec_t vec[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Completion scoreboard and per-cycle strobe exclusivity.
  always @(negedge clock) begin
    if (!reset) begin
      check("strobe_onehot",
            64'(($countones({dc_rd_en, dc_wr_en_lsq, dc_wr_en_mem}) <= 1)), 64'd1);
      if (dc_wr_en_mem) fill_cnt++;
      if (lsq_done) begin
        check("done_pending", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) check("done_data", lsq_rd_data, sb_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns 1 time unit after the accepting posedge.
  task automatic issue(input logic st, input logic [31:0] a, input logic [63:0] d,
                       input logic [2:0] sz, input logic [63:0] exp_rd);
    int n = 0;
    while (!lsq_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", 64'(lsq_ready), 64'd1);
    lsq_valid    = 1'b1;
    lsq_is_store = st;
    lsq_addr     = a;
    lsq_data     = d;
    lsq_size     = sz;
    sb_q.push_back(exp_rd);
    @(posedge clock);
    #1;
    lsq_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fc0;
    vec[0] = '{1'b0, 32'h0000_0048, 64'h0, 3'd3, 64'h1111_2222_3333_4444, 4'h9, 25'h0, 1'b0};
    vec[1] = '{1'b1, 32'h0000_1004, 64'hDEAD_BEEF, 3'd2, 64'h0, 4'h0, 25'h20, 1'b1};
    vec[2] = '{1'b0, 32'hFFFF_FFFC, 64'h0, 3'd3, 64'h0123_4567_89AB_CDEF, 4'hF, 25'h1FF_FFFF, 1'b1};
    vec[3] = '{1'b1, 32'h8000_0078, 64'hAB, 3'd0, 64'h0, 4'hF, 25'h100_0000, 1'b0};
    vec[4] = '{1'b0, 32'h0000_0080, 64'h0, 3'd3, 64'h5A5A_A5A5_0F0F_F0F0, 4'h0, 25'h1, 1'b0};

    reset = 1'b1;
    lsq_valid = 0; lsq_is_store = 0; lsq_addr = '0; lsq_data = '0; lsq_size = '0;
    dc_rd_valid = 0; dc_wr_valid = 0; dc_rd_data = '0;
    dc_evict_en = 0; dc_evict_data = '0; dc_evict_addr = '0;
    mem_response = '0; mem_tag = '0; mem_rd_data = '0;
    last_load = '0;
    repeat (2) @(negedge clock);
    check("rst_ready", 64'(lsq_ready), 64'd1);
    check("rst_done", 64'(lsq_done), 64'd0);
    check("rst_rd_data", lsq_rd_data, 64'd0);
    check("rst_strobes", 64'({dc_rd_en, dc_wr_en_lsq, dc_wr_en_mem}), 64'd0);
    check("rst_mem_cmd", 64'(mem_command), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_data", mem_data, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Hit vectors.
    for (int i = 0; i < 5; i++) begin
      dc_rd_valid = 1'b1;
      dc_wr_valid = 1'b1;
      dc_rd_data  = vec[i].rdata;
      if (!vec[i].st) last_load = vec[i].rdata;
      issue(vec[i].st, vec[i].addr, vec[i].data, vec[i].size, last_load);
      @(negedge clock);
      check("hit_rd_en", 64'(dc_rd_en), 64'(!vec[i].st));
      check("hit_wr_en_lsq", 64'(dc_wr_en_lsq), 64'(vec[i].st));
      check("hit_idx", 64'(dc_idx), 64'(vec[i].e_idx));
      check("hit_tag", 64'(dc_tag), 64'(vec[i].e_tag));
      check("hit_offset", 64'(dc_offset), 64'(vec[i].e_off));
      check("hit_size", 64'(dc_size), 64'(vec[i].size));
      check("hit_busy", 64'(lsq_ready), 64'd0);
      check("hit_no_mem", 64'(mem_command), 64'd0);
      if (vec[i].st) check("hit_wr_data", dc_wr_data, vec[i].data);
      @(negedge clock);
      check("hit_done", 64'(lsq_done), 64'd1);
      check("hit_ready_again", 64'(lsq_ready), 64'd1);
    end

    // Clean load miss with delayed acceptance and a foreign tag.
    dc_rd_valid = 1'b0; dc_wr_valid = 1'b0; mem_response = '0;
    last_load = 64'hCAFE_F00D_0123_4567;
    fc0 = fill_cnt;
    issue(1'b0, 32'h0000_2014, 64'h0, 3'd3, last_load);
    @(negedge clock);
    check("miss_lookup_rd_en", 64'(dc_rd_en), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("miss_load_cmd", 64'(mem_command), 64'd1);
      check("miss_load_addr", 64'(mem_addr), 64'h2010);
      if (i == 3) mem_response = 4'd5;
    end
    @(negedge clock);
    mem_response = '0;
    check("miss_wait_cmd", 64'(mem_command), 64'd0);
    mem_tag = 4'd3; mem_rd_data = 64'h3333_3333_3333_3333;
    @(negedge clock);
    check("miss_tag3_ignored", 64'(dc_wr_en_mem), 64'd0);
    mem_tag = 4'd5; mem_rd_data = 64'hCAFE_F00D_0123_4567;
    @(negedge clock);
    mem_tag = '0; mem_rd_data = '0;
    check("fill_wr_en_mem", 64'(dc_wr_en_mem), 64'd1);
    check("fill_wr_data", dc_wr_data, 64'hCAFE_F00D_0123_4567);
    check("fill_changed", 64'(dc_changed_data), 64'd0);
    dc_rd_valid = 1'b1; dc_rd_data = dc_wr_data;
    @(negedge clock);
    check("evchk_idle_bus", 64'({dc_rd_en, dc_wr_en_lsq, dc_wr_en_mem, mem_command}), 64'd0);
    @(negedge clock);
    check("replay_rd_en", 64'(dc_rd_en), 64'd1);
    @(negedge clock);
    check("miss_done", 64'(lsq_done), 64'd1);
    check("miss_fill_once", 64'(fill_cnt - fc0), 64'd1);

    // Store miss with dirty victim and a retried writeback.
    dc_wr_valid = 1'b0;
    issue(1'b1, 32'h0000_3008, 64'h0000_0000_5555_AAAA, 3'd3, last_load);
    @(negedge clock);
    check("ev_lookup_wr_en", 64'(dc_wr_en_lsq), 64'd1);
    @(negedge clock);
    check("ev_load_addr", 64'(mem_addr), 64'h3008);
    mem_response = 4'd2;
    @(negedge clock);
    mem_response = '0; mem_tag = 4'd2; mem_rd_data = 64'hF2F2_F2F2_F2F2_F2F2;
    @(negedge clock);
    mem_tag = '0;
    check("ev_fill", 64'(dc_wr_en_mem), 64'd1);
    dc_evict_en = 1'b1; dc_evict_addr = 32'h0000_5008; dc_evict_data = 64'hE0E0_1234_E0E0_5678;
    @(negedge clock);
    check("ev_chk_strobes", 64'({dc_rd_en, dc_wr_en_lsq, dc_wr_en_mem}), 64'd0);
    @(negedge clock);
    dc_evict_en = 1'b0; dc_evict_addr = '0; dc_evict_data = '0; dc_wr_valid = 1'b1;
    check("wb_cmd", 64'(mem_command), 64'd2);
    check("wb_addr", 64'(mem_addr), 64'h5008);
    check("wb_data", mem_data, 64'hE0E0_1234_E0E0_5678);
    @(negedge clock);
    check("wb_retry_cmd", 64'(mem_command), 64'd2);
    mem_response = 4'd7;
    @(negedge clock);
    mem_response = '0;
    check("ev_replay_wr_en", 64'(dc_wr_en_lsq), 64'd1);
    check("ev_replay_data", dc_wr_data, 64'h0000_0000_5555_AAAA);
    @(negedge clock);
    check("ev_done", 64'(lsq_done), 64'd1);

    // Reset while waiting for miss data abandons the request.
    dc_rd_valid = 1'b0;
    issue(1'b0, 32'h0000_4000, 64'h0, 3'd3, 64'hBAD0_BAD0_BAD0_BAD0);
    @(negedge clock);
    @(negedge clock);
    mem_response = 4'd4;
    @(negedge clock);
    mem_response = '0;
    reset = 1'b1;
    sb_q.delete();
    last_load = '0;
    #1;
    check("rst_mw_ready", 64'(lsq_ready), 64'd1);
    check("rst_mw_cmd", 64'(mem_command), 64'd0);
    check("rst_mw_done", 64'(lsq_done), 64'd0);
    check("rst_mw_rd_data", lsq_rd_data, 64'd0);
    fc0 = fill_cnt;
    @(negedge clock);
    reset = 1'b0;
    mem_tag = 4'd4; mem_rd_data = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("late_tag_ready", 64'(lsq_ready), 64'd1);
      check("late_tag_done", 64'(lsq_done), 64'd0);
    end
    mem_tag = '0;
    check("late_tag_no_fill", 64'(fill_cnt - fc0), 64'd0);

    // lsq_valid held through a miss; a changed address must not be latched.
    last_load = 64'h6666_0000_6666_0000;
    lsq_valid = 1'b1; lsq_is_store = 1'b0; lsq_addr = 32'h0000_6018; lsq_size = 3'd3;
    sb_q.push_back(last_load);
    @(posedge clock);
    #1;
    lsq_addr = 32'h0000_7020;
    @(negedge clock);
    check("held_ready_lookup", 64'(lsq_ready), 64'd0);
    check("held_idx", 64'(dc_idx), 64'h3);
    mem_response = 4'd9;
    @(negedge clock);
    check("held_ready_req", 64'(lsq_ready), 64'd0);
    @(negedge clock);
    mem_response = '0; mem_tag = 4'd9; mem_rd_data = 64'h6666_0000_6666_0000;
    check("held_ready_wait", 64'(lsq_ready), 64'd0);
    @(negedge clock);
    mem_tag = '0;
    dc_rd_valid = 1'b1; dc_rd_data = dc_wr_data;
    check("held_ready_fill", 64'(lsq_ready), 64'd0);
    @(negedge clock);
    check("held_ready_evchk", 64'(lsq_ready), 64'd0);
    @(negedge clock);
    check("held_replay_idx", 64'(dc_idx), 64'h3);
    check("held_replay_tag", 64'(dc_tag), 64'hC0);
    @(negedge clock);
    check("held_done", 64'(lsq_done), 64'd1);
    lsq_valid = 1'b0;
    @(negedge clock);
    check("held_done_pulse", 64'(lsq_done), 64'd0);
    check("held_idle_ready", 64'(lsq_ready), 64'd1);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
